// File: rtl/submod_bus_arbiter_if.sv
// Bundle of the submod source buses, the shared output channel and the overflow flags.
// The arbiter uses the master modport; the sources and sink use the slave modport.
interface submod_bus_arbiter_if #(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 4
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_valid;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_SRC-1:0]        overflow;
    logic [NUM_SRC-1:0]        clr_overflow;

    modport master (
        input  src_data, src_valid, out_ready, clr_overflow,
        output out_data, out_src, out_valid, overflow
    );

    modport slave (
        output src_data, src_valid, out_ready, clr_overflow,
        input  out_data, out_src, out_valid, overflow
    );
endinterface

// File: rtl/submod_bus_arbiter.sv
// Round-robin merge of several non-backpressured submod buses onto one ready/valid channel.
// Each source has a small FIFO; full FIFOs drop words and raise a sticky overflow flag.
module submod_bus_arbiter_fifo #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              drop
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_V = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   ONE     = (AW+1)'(1);

    logic [AW:0]                     wr_ptr, rd_ptr, count;
    logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
    logic                            full, wr_en, rd_en;

    assign full  = (count == DEPTH_V);
    assign empty = (count == '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr + ONE == DEPTH_V) ? '0 : wr_ptr + ONE;
            if (rd_en) rd_ptr <= (rd_ptr + ONE == DEPTH_V) ? '0 : rd_ptr + ONE;
            case ({wr_en, rd_en})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

module submod_bus_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    submod_bus_arbiter_if.master bus
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]             empty, pop, drop;
    logic [NUM_SRC-1:0][DATA_W-1:0] head;
    logic [SRC_W-1:0]               last_grant, grant_idx, cand;
    logic                           grant_any, load;

    assign load = !bus.out_valid || bus.out_ready;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            submod_bus_arbiter_fifo #(
                .DATA_W    (DATA_W),
                .FIFO_DEPTH(FIFO_DEPTH)
            ) u_fifo (
                .clk  (clk),
                .rst  (rst),
                .push (bus.src_valid[i]),
                .din  (bus.src_data[i*DATA_W +: DATA_W]),
                .pop  (pop[i]),
                .dout (head[i]),
                .empty(empty[i]),
                .drop (drop[i])
            );
            assign pop[i] = load && grant_any && (grant_idx == SRC_W'(i));
        end
    endgenerate

    // Scan starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = SRC_W'((int'(last_grant) + k) % NUM_SRC);
            if (!grant_any && !empty[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            bus.overflow  <= '0;
            last_grant    <= SRC_W'(NUM_SRC - 1);
        end else begin
            bus.overflow <= (bus.overflow & ~bus.clr_overflow) | drop;
            if (load) begin
                if (grant_any) begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= head[grant_idx];
                    bus.out_src   <= grant_idx;
                    last_grant    <= grant_idx;
                end else begin
                    bus.out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_submod_bus_arbiter.sv
// Directed-vector bench for submod_bus_arbiter (2 sources, 4-bit data, depth 4).
module tb_submod_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    submod_bus_arbiter_if #(.NUM_SRC(2), .DATA_W(4)) bus ();

    submod_bus_arbiter #(.NUM_SRC(2), .DATA_W(4), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic s, input logic [3:0] d);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, "_src"},   32'(bus.out_src),   32'(s));
        chk({tag, "_data"},  32'(bus.out_data),  32'(d));
    endtask

    // Drive one cycle of inputs, take the edge, settle 1 time unit past it.
    task automatic cyc(input logic [1:0] v, input logic [3:0] d1, input logic [3:0] d0,
                       input logic rdy, input logic [1:0] clr);
        bus.src_valid    = v;
        bus.src_data     = {d1, d0};
        bus.out_ready    = rdy;
        bus.clr_overflow = clr;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] d0s [3] = '{4'd1, 4'd2, 4'd3};
    logic [3:0] d1s [3] = '{4'd9, 4'd8, 4'd7};
    logic       exp_s [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_d [6] = '{4'd1, 4'd9, 4'd2, 4'd8, 4'd3, 4'd7};

    initial begin
        rst              = 1'b1;
        bus.src_valid    = '0;
        bus.src_data     = '0;
        bus.out_ready    = 1'b0;
        bus.clr_overflow = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 1'b0, 4'h0);
        chk("reset_ovf", 32'(bus.overflow), 32'h0);
        rst = 1'b0;

        // single word from source 1
        cyc(2'b10, 4'hA, 4'h0, 1'b1, 2'b00);
        chk("single_lat", 32'(bus.out_valid), 32'h0);
        cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b00);
        chk_out("single", 1'b1, 1'b1, 4'hA);
        cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b00);
        chk("single_idle", 32'(bus.out_valid), 32'h0);

        // round-robin interleave, no gaps
        for (int t = 0; t < 8; t++) begin
            if (t < 3) cyc(2'b11, d1s[t], d0s[t], 1'b1, 2'b00);
            else       cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b00);
            if (t >= 1 && t <= 6) chk_out("rr", 1'b1, exp_s[t-1], exp_d[t-1]);
            if (t == 7) chk("rr_idle", 32'(bus.out_valid), 32'h0);
        end

        // backpressure: word 0 held, 1..4 buffered, 5 and 6 dropped
        for (int w = 0; w < 7; w++) begin
            cyc(2'b01, 4'h0, 4'(w), 1'b0, 2'b00);
            if (w >= 1) chk_out("bp_hold", 1'b1, 1'b0, 4'h0);
            chk("bp_ovf", 32'(bus.overflow), (w >= 5) ? 32'h1 : 32'h0);
        end
        for (int j = 1; j <= 4; j++) begin
            cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b00);
            chk_out("bp_drain", 1'b1, 1'b0, 4'(j));
        end
        cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b00);
        chk("bp_idle", 32'(bus.out_valid), 32'h0);

        // clear with no drop
        cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b01);
        chk("clr_ovf", 32'(bus.overflow), 32'h0);

        // full FIFO plus pop accepts the push
        for (int w = 0; w < 5; w++) cyc(2'b01, 4'h0, 4'hA + 4'(w), 1'b0, 2'b00);
        cyc(2'b01, 4'h0, 4'hF, 1'b1, 2'b00);
        chk("fp_ovf", 32'(bus.overflow), 32'h0);
        chk_out("fp", 1'b1, 1'b0, 4'hB);
        cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b00);
        chk_out("fp", 1'b1, 1'b0, 4'hC);
        cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b00);
        chk_out("fp", 1'b1, 1'b0, 4'hD);
        cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b00);
        chk_out("fp", 1'b1, 1'b0, 4'hE);
        cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b00);
        chk_out("fp_last", 1'b1, 1'b0, 4'hF);
        cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b00);
        chk("fp_idle", 32'(bus.out_valid), 32'h0);

        // set beats clear on the same edge
        for (int w = 0; w < 5; w++) cyc(2'b01, 4'h0, 4'(w), 1'b0, 2'b00);
        cyc(2'b01, 4'h0, 4'h5, 1'b0, 2'b00);
        chk("op_drop", 32'(bus.overflow), 32'h1);
        cyc(2'b11, 4'h3, 4'h6, 1'b0, 2'b01);
        chk("op_set_wins", 32'(bus.overflow), 32'h1);
        cyc(2'b10, 4'h4, 4'h0, 1'b0, 2'b01);
        chk("op_clr", 32'(bus.overflow), 32'h0);
        cyc(2'b01, 4'h0, 4'h7, 1'b0, 2'b00);
        chk("op_redrop", 32'(bus.overflow), 32'h1);
        chk("op_pending", 32'(bus.out_valid), 32'h1);

        // reset mid-stream; pushes during reset are ignored
        rst = 1'b1;
        cyc(2'b11, 4'h1, 4'h2, 1'b0, 2'b00);
        chk_out("mrst", 1'b0, 1'b0, 4'h0);
        chk("mrst_ovf", 32'(bus.overflow), 32'h0);
        rst = 1'b0;
        cyc(2'b11, 4'h6, 4'h5, 1'b1, 2'b00);
        cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b00);
        chk_out("post_rst", 1'b1, 1'b0, 4'h5);
        cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b00);
        chk_out("post_rst", 1'b1, 1'b1, 4'h6);
        cyc(2'b00, 4'h0, 4'h0, 1'b1, 2'b00);
        chk("post_rst_idle", 32'(bus.out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/submod_bus_arbiter.md
# submod_bus_arbiter

Round-robin arbiter that merges the `data_bus`/`valid` streams of several `submod_inst` instances (u_submod0, u_submod1, …) onto one shared output channel with ready/valid backpressure. The sources have no backpressure input, so each source gets a small FIFO that absorbs bursts while the shared sink is busy or owned by another source. A sticky per-source overflow flag records any dropped words. The block sits between the submod instance array and the single downstream consumer of their buses.

## Interface
- `NUM_SRC`, 2: number of submod sources; ≥2.
- `DATA_W`, 4: width of each source `data_bus`.
- `FIFO_DEPTH`, 4: entries per source FIFO; power of two, ≥2.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `src_data`  in  NUM_SRC*DATA_W  packed source buses; source i occupies bits [i*DATA_W +: DATA_W].
- `src_valid`  in  NUM_SRC  per-source valid; one word is offered per high cycle.
- `out_data`  out  DATA_W  granted word.
- `out_src`  out  max(1,$clog2(NUM_SRC))  index of the source that produced `out_data`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  sink accepts; a transfer occurs when `out_valid && out_ready`.
- `overflow`  out  NUM_SRC  sticky: source word dropped because its FIFO was full.
- `clr_overflow`  in  NUM_SRC  per-bit clear of `overflow`.

## Operation
- Per-source FIFO: write pointer, read pointer and count of width $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- Push: `src_valid[i]` high and (FIFO i not full, or FIFO i popped this cycle) → word written. Full and not popped → word dropped, `overflow[i]` set.
- `overflow[i]`: set has priority over `clr_overflow[i]` in the same cycle.
- Output register load condition: `load = !out_valid || out_ready`.
- On `load`: pick the first non-empty FIFO scanning round-robin from `last_grant+1` mod NUM_SRC. Pop it, register word into `out_data`, index into `out_src`, set `out_valid`, update `last_grant`.
- On `load` with all FIFOs empty: `out_valid` ← 0. `out_data`/`out_src` hold their last value.
- The arbiter uses FIFO state registered at the start of the cycle. A word pushed in cycle k cannot be granted before cycle k+1.
- Stall: `out_valid && !out_ready` → `out_data`, `out_src` and `out_valid` held stable, no pop, and `last_grant` unchanged.
- Fairness: with all sources continuously non-empty and `out_ready` high, grants cycle 0,1,…,NUM_SRC-1,0,…. No source waits more than NUM_SRC-1 transfers once it is at its FIFO head.
- Simultaneous push and pop on the same FIFO: both occur and the count is unchanged. This holds when the FIFO is full, so the push is not dropped.
- Simultaneous pushes on several sources: all are handled independently.

## Timing
- Reset values (when `rst` is sampled high): all FIFO pointers and counts 0, `out_valid` 0, `out_data` 0, `out_src` 0, `overflow` 0. `last_grant` = NUM_SRC-1, so source 0 has first priority.
- Reset mid-operation: FIFO contents and any pending output word are discarded. `src_valid` in the reset cycle is ignored.
- Latency: word offered at edge k (FIFO empty, output idle) → `out_valid` high after edge k+1, i.e. 2 cycles source-to-output minimum.
- Throughput: one word per cycle when `out_ready` is held high and any FIFO is non-empty.
- `out_ready` may toggle freely. The output register is the only path, so there is no combinational path from `out_ready` to `out_valid` or `out_data`.
- `overflow` updates one cycle after the dropping push. `clr_overflow` takes effect at the next edge.

## Test plan
- Single word: after reset, `src_data`=0x_A0 (src1=0xA, src0=0x0) with `src_valid`=2'b10 for 1 cycle and `out_ready`=1 → after 2 edges `out_valid`=1, `out_data`=0xA, `out_src`=1. Next cycle `out_valid`=0.
- Round-robin: both sources push 3 words (src0: 1,2,3; src1: 9,8,7) on the same cycles, `out_ready`=1 → output order (src,data) = (0,1),(1,9),(0,2),(1,8),(0,3),(1,7). There are no gaps after the first word.
- Backpressure/overflow: `out_ready`=0 and src0 pushes 7 words 0..6 → first word sits in the output register, FIFO holds 1..4, words 5,6 dropped, `overflow`=2'b01. Raising `out_ready` → 0,1,2,3,4 delivered in order, out_data stable while stalled.
- Full plus pop: src0 FIFO full, `out_ready`=1, src0 pushes 0xF in the same cycle → no overflow, 0xF later delivered.
- Overflow priority: `overflow[0]`=1, `clr_overflow[0]`=1 in the same cycle as a new drop → `overflow[0]` stays 1. Clear with no drop → 0.
- Reset mid-stream: assert `rst` for 1 cycle while both FIFOs are partially filled and `out_valid`=1 → `out_valid`=0 and `overflow`=0 next cycle. The first post-reset grant goes to source 0 when both sources push together.
